// File: rtl/piso_serializer_n.sv
// rtl/piso_serializer_n.sv - parallel-in/serial-out shifter with load handshake, markers and word counter
module piso_serializer_n #(
  parameter int   WIDTH    = 8,
  parameter int   CNT_W    = 16,
  parameter logic IDLE_LVL = 1'b0,
  parameter logic FILL     = 1'b0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             en_i,
  input  logic             dir_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             valid_i,
  output logic             ready_o,
  output logic             q_o,
  output logic             q_valid_o,
  output logic             first_o,
  output logic             last_o,
  output logic             done_o,
  output logic [CNT_W-1:0] wcnt_o
);

  localparam int BW = $clog2(WIDTH);
  localparam logic [BW-1:0] TOP = BW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] wcnt_q, wcnt_d;
  logic             done_q, done_d;
  logic             rdy_en_q;
  logic             last_bit;
  logic             xfer;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      sr_q     <= '0;
      bitcnt_q <= '0;
      dir_q    <= 1'b0;
      wcnt_q   <= '0;
      done_q   <= 1'b0;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      bitcnt_q <= bitcnt_d;
      dir_q    <= dir_d;
      wcnt_q   <= wcnt_d;
      done_q   <= done_d;
      rdy_en_q <= 1'b1;
    end
  end

  // The last-bit cycle also accepts a new word so back-to-back words have no gap.
  always_comb begin
    last_bit = (state_q == SHIFT) && (bitcnt_q == '0);
    ready_o  = rdy_en_q & en_i & ((state_q == IDLE) | last_bit);
    xfer     = valid_i & ready_o;

    state_d  = state_q;
    sr_d     = sr_q;
    bitcnt_d = bitcnt_q;
    dir_d    = dir_q;
    wcnt_d   = wcnt_q;
    done_d   = done_q;

    if (en_i) begin
      done_d = last_bit;
      if (last_bit) begin
        wcnt_d  = wcnt_q + CNT_W'(1);
        state_d = IDLE;
      end
      if (xfer) begin
        sr_d     = data_i;
        dir_d    = dir_i;
        bitcnt_d = TOP;
        state_d  = SHIFT;
      end else if (state_q == SHIFT && !last_bit) begin
        bitcnt_d = bitcnt_q - BW'(1);
        sr_d     = dir_q ? {sr_q[WIDTH-2:0], FILL} : {FILL, sr_q[WIDTH-1:1]};
      end
    end
  end

  always_comb begin
    q_valid_o = (state_q == SHIFT);
    q_o       = q_valid_o ? (dir_q ? sr_q[WIDTH-1] : sr_q[0]) : IDLE_LVL;
    first_o   = q_valid_o && (bitcnt_q == TOP);
    last_o    = last_bit;
    done_o    = done_q;
    wcnt_o    = wcnt_q;
  end

endmodule

// File: tb/tb_piso_serializer_n.sv
// tb/tb_piso_serializer_n.sv - directed self-checking bench for piso_serializer_n
module tb_piso_serializer_n;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en, dir, valid;
  logic [7:0]  data;
  logic        ready, q, q_valid, first, last, done;
  logic [15:0] wcnt;

  logic        en12, dir12, valid12;
  logic [11:0] data12;
  logic        ready12, q12, q_valid12, first12, last12, done12;
  logic [1:0]  wcnt12;

  int n_checks = 0;
  int n_errors = 0;
  int exp_wcnt = 0;

  always #5 clk = ~clk;

  piso_serializer_n #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en), .dir_i(dir), .data_i(data), .valid_i(valid),
    .ready_o(ready), .q_o(q), .q_valid_o(q_valid), .first_o(first), .last_o(last),
    .done_o(done), .wcnt_o(wcnt)
  );

  piso_serializer_n #(.WIDTH(12), .CNT_W(2)) u_dut12 (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en12), .dir_i(dir12), .data_i(data12), .valid_i(valid12),
    .ready_o(ready12), .q_o(q12), .q_valid_o(q_valid12), .first_o(first12), .last_o(last12),
    .done_o(done12), .wcnt_o(wcnt12)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Send one 8-bit word; optionally stall EN after bit stall_at or reset after bit rst_at.
  task automatic run8(input logic [7:0] d, input logic dr, input int stall_at, input int rst_at);
    @(negedge clk);
    check_eq("ready_idle", ready, 1);
    valid = 1'b1; data = d; dir = dr;
    @(posedge clk); #1;
    valid = 1'b0; dir = ~dr; data = ~d;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq("q_valid", q_valid, 1);
      check_eq("q_bit", q, dr ? d[7-i] : d[i]);
      check_eq("first", first, (i == 0));
      check_eq("last", last, (i == 7));
      if (i == stall_at) begin
        en = 1'b0;
        repeat (3) begin
          @(negedge clk);
          check_eq("stall_q", q, dr ? d[7-i] : d[i]);
          check_eq("stall_ready", ready, 0);
          check_eq("stall_qv", q_valid, 1);
        end
        en = 1'b1;
      end
      if (i == rst_at) begin
        rst_n = 1'b0; #1;
        check_eq("rst_q", q, 0);
        check_eq("rst_ready", ready, 0);
        check_eq("rst_qv", q_valid, 0);
        check_eq("rst_wcnt", wcnt, 0);
        exp_wcnt = 0;
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1; #1;
        check_eq("rel_ready", ready, 0);
        @(posedge clk); #1;
        check_eq("rel_ready1", ready, 1);
        @(negedge clk);
        check_eq("rel_done", done, 0);
        check_eq("rel_wcnt", wcnt, 0);
        return;
      end
    end
    exp_wcnt++;
    @(negedge clk);
    check_eq("done", done, 1);
    check_eq("q_valid_end", q_valid, 0);
    check_eq("wcnt", wcnt, exp_wcnt);
    @(negedge clk);
    check_eq("done_pulse", done, 0);
  endtask

  localparam logic [1:0] WSEQ [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  initial begin
    rst_n = 1'b0; en = 1'b1; dir = 1'b0; valid = 1'b0; data = '0;
    en12 = 1'b1; dir12 = 1'b1; valid12 = 1'b0; data12 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset_ready", ready, 0);
    check_eq("reset_q", q, 0);
    check_eq("reset_qv", q_valid, 0);
    check_eq("reset_wcnt", wcnt, 0);
    check_eq("reset_done", done, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("ready_after_rel", ready, 1);

    // T1, T2
    run8(8'hA5, 1'b1, -1, -1);
    run8(8'hA5, 1'b0, -1, -1);
    run8(8'h01, 1'b0, -1, -1);
    run8(8'h01, 1'b1, -1, -1);

    // T3: back-to-back FF then 00 with VALID held high
    @(negedge clk);
    valid = 1'b1; data = 8'hFF; dir = 1'b1;
    @(posedge clk); #1;
    data = 8'h00;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check_eq("b2b_qv", q_valid, 1);
      check_eq("b2b_q", q, (i < 8));
      check_eq("b2b_last", last, (i == 7 || i == 15));
      if (i == 7 || i == 15) check_eq("b2b_ready", ready, 1);
      else check_eq("b2b_notready", ready, 0);
      if (i == 8) check_eq("b2b_done1", done, 1);
      if (i == 7) begin
        @(posedge clk); #1;
        valid = 1'b0;
      end
    end
    exp_wcnt += 2;
    @(negedge clk);
    check_eq("b2b_done2", done, 1);
    check_eq("b2b_wcnt", wcnt, exp_wcnt);

    // T4: EN stall after 3rd bit
    run8(8'hC3, 1'b1, 2, -1);
    // T5: reset after 4th bit
    run8(8'h5A, 1'b1, -1, 3);
    run8(8'h3C, 1'b0, -1, -1);

    // T6: WIDTH=12, CNT_W=2 counter wrap
    for (int w = 0; w < 5; w++) begin
      logic [11:0] d12;
      d12 = 12'hA3C ^ 12'(w * 12'h111);
      @(negedge clk);
      valid12 = 1'b1; data12 = d12;
      @(posedge clk); #1;
      valid12 = 1'b0;
      for (int i = 0; i < 12; i++) begin
        @(negedge clk);
        check_eq("w12_qv", q_valid12, 1);
        check_eq("w12_q", q12, d12[11-i]);
        check_eq("w12_last", last12, (i == 11));
      end
      @(negedge clk);
      check_eq("w12_done", done12, 1);
      check_eq("w12_wcnt", wcnt12, WSEQ[w]);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
